// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage of the single-cycle MIPS core.
// Decodes {aluop, funct} into a 4-bit ALU control code and runs the ALU.
// Also computes the PC+4 and branch-target adders.
// Every output is registered one cycle behind the valid_in strobe.
module alu_exec_stage #(
    parameter int          WIDTH   = 32,
    parameter int unsigned PC_STEP = 4
) (
    input  logic             clk,
    input  logic             startin,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm_ext,
    output logic             valid_out,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target
);

    typedef enum logic [3:0] {
        CTRL_AND = 4'b0000,
        CTRL_OR  = 4'b0001,
        CTRL_ADD = 4'b0010,
        CTRL_SUB = 4'b0110,
        CTRL_SLT = 4'b0111,
        CTRL_NOR = 4'b1100
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    alu_ctrl_e        w_ctrl;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_branch_target;

    alu_ctrl_e        r_ctrl;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [WIDTH-1:0] r_pc_plus4;
    logic [WIDTH-1:0] r_branch_target;

    // Control decode: aluop picks the op directly except for R-type, where funct decides.
    always_comb begin
        // NOTE: default assigned first so every path drives w_ctrl and no latch is inferred.
        w_ctrl = CTRL_ADD;
        case (aluop_e'(aluop))
            ALUOP_ADD: w_ctrl = CTRL_ADD;
            ALUOP_SUB: w_ctrl = CTRL_SUB;
            ALUOP_OR:  w_ctrl = CTRL_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    6'b100000: w_ctrl = CTRL_ADD;
                    6'b100010: w_ctrl = CTRL_SUB;
                    6'b100100: w_ctrl = CTRL_AND;
                    6'b100101: w_ctrl = CTRL_OR;
                    6'b100111: w_ctrl = CTRL_NOR;
                    6'b101010: w_ctrl = CTRL_SLT;
                    default:   w_ctrl = CTRL_ADD;  // unknown funct falls back to add
                endcase
            end
            default: w_ctrl = CTRL_ADD;
        endcase
    end

    // ALU: add/sub wrap modulo 2^WIDTH; slt is a signed compare; unknown codes give 0.
    always_comb begin
        w_result = '0;
        case (w_ctrl)
            CTRL_AND: w_result = a & b;
            CTRL_OR:  w_result = a | b;
            CTRL_ADD: w_result = a + b;
            CTRL_SUB: w_result = a - b;
            CTRL_SLT: w_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            CTRL_NOR: w_result = ~(a | b);
            default:  w_result = '0;
        endcase
    end

    // PC adders; the left shift of imm_ext discards its top two bits, both sums wrap.
    always_comb begin
        w_pc_plus4      = pc + WIDTH'(PC_STEP);
        w_branch_target = w_pc_plus4 + (imm_ext << 2);
    end

    // Output registers: valid follows valid_in every edge, data loads only on valid_in.
    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            r_valid         <= 1'b0;
            r_ctrl          <= CTRL_AND;
            r_result        <= '0;
            r_zero          <= 1'b0;
            r_pc_plus4      <= '0;
            r_branch_target <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_valid <= valid_in;
            if (valid_in) begin
                r_ctrl          <= w_ctrl;
                r_result        <= w_result;
                r_zero          <= (w_result == '0);  // from the same-cycle result
                r_pc_plus4      <= w_pc_plus4;
                r_branch_target <= w_branch_target;
            end
        end
    end

    assign valid_out     = r_valid;
    assign alu_ctrl      = r_ctrl;
    assign alu_result    = r_result;
    assign zero          = r_zero;
    assign pc_plus4      = r_pc_plus4;
    assign branch_target = r_branch_target;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: directed scenarios plus randomized traffic
// checked against an arithmetic reference model.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        startin = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] a = '0, b = '0, pc = '0, imm_ext = '0;
    logic [1:0]  aluop = '0;
    logic [5:0]  funct = '0;

    logic        valid_out, zero;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result, pc_plus4, branch_target;

    int n_total = 0;
    int n_pass  = 0;

    // Expected registered state: {ctrl, result, zero, pc_plus4, branch_target}
    logic [100:0] exp_data  = '0;
    logic         exp_valid = 1'b0;
    logic [100:0] got_data;

    assign got_data = {alu_ctrl, alu_result, zero, pc_plus4, branch_target};

    alu_exec_stage dut (
        .clk          (clk),
        .startin      (startin),
        .valid_in     (valid_in),
        .a            (a),
        .b            (b),
        .aluop        (aluop),
        .funct        (funct),
        .pc           (pc),
        .imm_ext      (imm_ext),
        .valid_out    (valid_out),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .zero         (zero),
        .pc_plus4     (pc_plus4),
        .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    localparam longint M = 64'sd4294967296;

    function automatic longint wrap32(input longint x);
        return ((x % M) + M) % M;
    endfunction

    // Reference model computed from the instruction semantics with plain integer math.
    function automatic logic [100:0] model(input logic [1:0] op, input logic [5:0] fn,
                                           input logic [31:0] ia, input logic [31:0] ib,
                                           input logic [31:0] ipc, input logic [31:0] iimm);
        logic [3:0]  ctrl;
        logic [31:0] res, p4, bt;
        if (op == 2'b00)      ctrl = 4'b0010;
        else if (op == 2'b01) ctrl = 4'b0110;
        else if (op == 2'b11) ctrl = 4'b0001;
        else if (fn == 6'h22) ctrl = 4'b0110;
        else if (fn == 6'h24) ctrl = 4'b0000;
        else if (fn == 6'h25) ctrl = 4'b0001;
        else if (fn == 6'h27) ctrl = 4'b1100;
        else if (fn == 6'h2A) ctrl = 4'b0111;
        else                  ctrl = 4'b0010;
        case (ctrl)
            4'b0000: res = ia & ib;
            4'b0001: res = ia | ib;
            4'b0010: res = 32'(wrap32(longint'(ia) + longint'(ib)));
            4'b0110: res = 32'(wrap32(longint'(ia) - longint'(ib)));
            4'b0111: res = (int'(ia) < int'(ib)) ? 32'd1 : 32'd0;
            4'b1100: res = ~(ia | ib);
            default: res = 32'd0;
        endcase
        p4 = 32'(wrap32(longint'(ipc) + 4));
        bt = 32'(wrap32(longint'(ipc) + 4 + longint'(int'(iimm)) * 4));
        return {ctrl, res, (res == 32'd0), p4, bt};
    endfunction

    // Drive one cycle of inputs at the falling edge, update the scoreboard, sample after the rise.
    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] ipc, input logic [31:0] iimm);
        @(negedge clk);
        valid_in = v; aluop = op; funct = fn; a = ia; b = ib; pc = ipc; imm_ext = iimm;
        if (startin) begin
            exp_valid = v;
            if (v) exp_data = model(op, fn, ia, ib, ipc, iimm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        startin = 1'b0;
        drive(1'b1, 2'($urandom), 6'($urandom), $urandom, $urandom, $urandom, $urandom);
        drive(1'b1, 2'($urandom), 6'($urandom), $urandom, $urandom, $urandom, $urandom);
        n_total++;
        if ({valid_out, got_data} !== 102'd0)
            $display("FAIL reset_hold: got %h expected 0", {valid_out, got_data});
        else n_pass++;
        startin = 1'b1;
        drive(1'b1, 2'($urandom), 6'($urandom), $urandom, $urandom, $urandom, $urandom);
        n_total++;
        if (valid_out !== 1'b1 || got_data !== exp_data)
            $display("FAIL reset_release: got %b/%h expected 1/%h", valid_out, got_data, exp_data);
        else n_pass++;
    endtask

    task automatic test_add_sub();
        drive(1'b1, 2'b10, 6'b100000, 32'd7, 32'd5, 32'h100, 32'h0);
        n_total++;
        if (alu_result !== 32'd12 || alu_ctrl !== 4'b0010 || zero !== 1'b0)
            $display("FAIL add_7_5: got %h/%b/%b expected 0000000c/0010/0", alu_result, alu_ctrl, zero);
        else n_pass++;
        drive(1'b1, 2'b10, 6'b100010, 32'd5, 32'd5, 32'h100, 32'h0);
        n_total++;
        if (alu_result !== 32'd0 || alu_ctrl !== 4'b0110 || zero !== 1'b1)
            $display("FAIL sub_5_5: got %h/%b/%b expected 00000000/0110/1", alu_result, alu_ctrl, zero);
        else n_pass++;
    endtask

    task automatic test_logic_slt();
        logic [31:0] want [5];
        logic [5:0]  fns  [5];
        logic [31:0] as   [5];
        logic [31:0] bs   [5];
        want = '{32'd1, 32'd0, 32'h00F000F0, 32'hFFF0FFF0, 32'h000F000F};
        fns  = '{6'h2A, 6'h2A, 6'h24, 6'h25, 6'h27};
        as   = '{32'hFFFFFFFF, 32'd1, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
        bs   = '{32'd1, 32'hFFFFFFFF, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b10, fns[i], as[i], bs[i], 32'h0, 32'h0);
            n_total++;
            if (alu_result !== want[i] || zero !== (want[i] == 32'd0))
                $display("FAIL logic_slt_%0d: got %h/%b expected %h", i, alu_result, zero, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 2'b00, 6'h3F, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
        n_total++;
        if (alu_result !== 32'd0 || zero !== 1'b1 || alu_ctrl !== 4'b0010)
            $display("FAIL add_wrap: got %h/%b/%b expected 00000000/1/0010", alu_result, zero, alu_ctrl);
        else n_pass++;
        drive(1'b1, 2'b01, 6'h00, 32'd0, 32'd1, 32'h0, 32'h0);
        n_total++;
        if (alu_result !== 32'hFFFFFFFF || zero !== 1'b0 || alu_ctrl !== 4'b0110)
            $display("FAIL sub_wrap: got %h/%b/%b expected ffffffff/0/0110", alu_result, zero, alu_ctrl);
        else n_pass++;
        drive(1'b1, 2'b10, 6'b000011, 32'd3, 32'd4, 32'h0, 32'h0);
        n_total++;
        if (alu_result !== 32'd7 || alu_ctrl !== 4'b0010)
            $display("FAIL undef_funct: got %h/%b expected 00000007/0010", alu_result, alu_ctrl);
        else n_pass++;
    endtask

    task automatic test_pc();
        drive(1'b1, 2'b11, 6'h0, 32'h0, 32'h0, 32'h00000010, 32'hFFFFFFFF);
        n_total++;
        if (pc_plus4 !== 32'h14 || branch_target !== 32'h10)
            $display("FAIL pc_neg_off: got %h/%h expected 00000014/00000010", pc_plus4, branch_target);
        else n_pass++;
        drive(1'b1, 2'b11, 6'h0, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h1);
        n_total++;
        if (pc_plus4 !== 32'h0 || branch_target !== 32'h4)
            $display("FAIL pc_wrap: got %h/%h expected 00000000/00000004", pc_plus4, branch_target);
        else n_pass++;
        drive(1'b1, 2'b11, 6'h0, 32'h0, 32'h0, 32'h00001000, 32'hC0000001);
        n_total++;
        if (branch_target !== 32'h00001008)
            $display("FAIL imm_top_bits: got %h expected 00001008", branch_target);
        else n_pass++;
    endtask

    task automatic test_hold_and_async_reset();
        drive(1'b1, 2'b00, 6'h0, 32'd100, 32'd23, 32'h40, 32'd2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'($urandom), 6'($urandom), $urandom, $urandom, $urandom, $urandom);
            n_total++;
            if (valid_out !== 1'b0 || alu_result !== 32'd123 || pc_plus4 !== 32'h44 ||
                branch_target !== 32'h4C || got_data !== exp_data)
                $display("FAIL hold_%0d: got %b/%h expected 0/%h", i, valid_out, got_data, exp_data);
            else n_pass++;
        end
        drive(1'b1, 2'b00, 6'h0, 32'd9, 32'd9, 32'h80, 32'd0);
        #2;
        startin = 1'b0;
        #1;
        n_total++;
        if ({valid_out, got_data} !== 102'd0)
            $display("FAIL async_clear: got %h expected 0", {valid_out, got_data});
        else n_pass++;
        exp_valid = 1'b0;
        exp_data  = '0;
        startin   = 1'b1;
        drive(1'b0, 2'b00, 6'h0, 32'd1, 32'd1, 32'h4, 32'h4);
        n_total++;
        if ({valid_out, got_data} !== 102'd0)
            $display("FAIL post_reset_hold: got %h expected 0", {valid_out, got_data});
        else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0] fn_pool [8];
        int errs = 0;
        fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h21};
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            drive(($urandom_range(0, 3) != 0), 2'($urandom), fn_pool[$urandom_range(0, 7)],
                  ra, rb, $urandom, $urandom);
            n_total++;
            if (valid_out !== exp_valid || got_data !== exp_data) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d: got %b/%h expected %b/%h",
                             i, valid_out, got_data, exp_valid, exp_data);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic_slt();
        test_wrap();
        test_pc();
        test_hold_and_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
